// File: rtl/dffram_dp.sv
// dffram_dp: dual-port word RAM built from flip-flops.
//   Port A: read/write with byte write enables, read-first, 1-cycle read latency.
//   Port B: read-only, 1-cycle read latency, optional forwarding of port A write data.
// A scrub engine zeroes every word after reset and on CLR, so contents are deterministic.
//
// Access handshake: READY is the acceptance signal. A port access (EN_A / EN_B, WE_A)
// is performed on a rising edge only if READY was 1 before that edge. While READY is 0
// all port inputs and CLR are ignored and Do_A / Do_B hold. CLR is taken on an edge with
// READY=1; READY drops after that edge and rises again WORDS edges later. A port access
// presented together with CLR is still performed.
module dffram_dp #(
    parameter int WORDS  = 256,
    parameter int AW     = 8,
    parameter int BYTES  = 4,
    parameter int BYPASS = 1
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 CLR,
    output logic                 READY,
    input  logic                 EN_A,
    input  logic [BYTES-1:0]     WE_A,
    input  logic [AW-1:0]        A_A,
    input  logic [8*BYTES-1:0]   Di_A,
    output logic [8*BYTES-1:0]   Do_A,
    input  logic                 EN_B,
    input  logic [AW-1:0]        A_B,
    output logic [8*BYTES-1:0]   Do_B,
    output logic                 STATE_DBG    // 1 while the scrub engine owns the array
);

    localparam int DW = 8 * BYTES;
    // Last word index, and the word count widened by one bit so the range check
    // works even when WORDS == 2**AW.
    localparam logic [AW-1:0] LAST    = AW'(WORDS - 1);
    localparam logic [AW:0]   WORDS_W = (AW + 1)'(WORDS);

    typedef enum logic {
        SCRUB = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;

    logic [DW-1:0]   mem [WORDS];

    logic            acc;
    logic            a_ok;
    logic            b_ok;
    logic [DW-1:0]   rd_a;
    logic [DW-1:0]   rd_b;

    assign acc       = (state_q == IDLE);
    assign a_ok      = ({1'b0, A_A} < WORDS_W);
    assign b_ok      = ({1'b0, A_B} < WORDS_W);
    assign READY     = ready_q;
    assign STATE_DBG = (state_q == SCRUB);

    // Control state register: scrub state, scrub counter and READY.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= SCRUB;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic: walk the counter across all words, then wait for CLR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            SCRUB: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (CLR) begin
                    state_d = SCRUB;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = SCRUB;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Read data before the edge; out-of-range addresses read as zero.
    // Port B optionally takes the bytes port A is writing to the same word.
    always_comb begin
        rd_a = a_ok ? mem[A_A] : '0;
        rd_b = b_ok ? mem[A_B] : '0;
        if ((BYPASS != 0) && EN_A && b_ok && (A_A == A_B)) begin
            for (int i = 0; i < BYTES; i++) begin
                if (WE_A[i]) begin
                    rd_b[8*i +: 8] = Di_A[8*i +: 8];
                end
            end
        end
    end

    // Array update: scrub zeroes one word per edge, otherwise port A byte writes.
    always_ff @(posedge CLK) begin
        if (state_q == SCRUB) begin
            mem[cnt_q] <= '0;
        end else if (EN_A && a_ok) begin
            for (int i = 0; i < BYTES; i++) begin
                if (WE_A[i]) begin
                    mem[A_A][8*i +: 8] <= Di_A[8*i +: 8];
                end
            end
        end
    end

    // Registered read outputs; hold when the port is idle or the array is scrubbing.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Do_A <= '0;
            Do_B <= '0;
        end else if (acc) begin
            if (EN_A) begin
                Do_A <= rd_a;
            end
            if (EN_B) begin
                Do_B <= rd_b;
            end
        end
    end

endmodule

// File: doc/dffram_dp.md
# dffram_dp

Parametrised dual-port successor to the single-port mock DFFRAM used in FPGA bring-up builds. It provides one read/write port with byte write enables and one independent read-only port, both with one-cycle synchronous read latency. A built-in scrub state machine zeroes the whole array after reset or on request, so simulation and FPGA runs start from deterministic contents. It sits behind the CPU bus adapter in place of the mock RAM; port B serves instruction fetch or debug reads.

## Interface
- WORDS, 256: number of words; any value ≥ 2, need not be a power of two.
- AW, 8: address width; must satisfy 2**AW ≥ WORDS.
- BYTES, 4: bytes per word; data width is 8*BYTES.
- BYPASS, 1: 1 = port B forwards same-cycle port A write data; 0 = port B returns old data.

- CLK  in  1  clock; all state changes on the rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous request to re-scrub the array; sampled only in IDLE.
- READY  out  1  1 = scrub complete, ports accept accesses.
- EN_A  in  1  port A enable.
- WE_A  in  BYTES  port A byte write enables; bit i covers Di_A[8i+7:8i].
- A_A  in  AW  port A word address.
- Di_A  in  8*BYTES  port A write data.
- Do_A  out  8*BYTES  port A registered read data.
- EN_B  in  1  port B enable.
- A_B  in  AW  port B word address.
- Do_B  out  8*BYTES  port B registered read data.

## Operation
- States: SCRUB and IDLE. A scrub counter of width AW and a READY register make up the rest of the control state.
- Reset (RSTn low):
  - State goes to SCRUB, counter to 0, READY to 0, Do_A and Do_B to 0.
  - Array contents are not reset directly.
- SCRUB:
  - Each edge writes all-zero to mem[counter] and increments the counter.
  - The edge that writes word WORDS-1 moves the state to IDLE and sets READY=1.
  - EN_A, EN_B, WE_A and CLR are ignored; Do_A and Do_B hold their values.
- IDLE:
  - CLR=1 moves the state to SCRUB on the next edge, with counter=0 and READY=0.
  - A port access in the same cycle as CLR is still performed.
- Port A, when EN_A=1 in IDLE:
  - Do_A loads mem[A_A] as it was before the edge (read-first).
  - Each byte with WE_A[i]=1 is written from Di_A; other bytes are unchanged.
- Port B, when EN_B=1 in IDLE:
  - Do_B loads mem[A_B].
  - If BYPASS=1, EN_A=1 and A_A==A_B, the bytes with WE_A set are taken from Di_A and the rest from memory.
  - If BYPASS=0, Do_B loads the old data.
- When EN is low, the port's Do register holds its value.
- Address ≥ WORDS: the read loads 0 into Do; writes are dropped; no wrap-around aliasing.
- Reset asserted mid-scrub: the scrub restarts from word 0 after release. Reset asserted mid-access: the write may or may not land; the read data is discarded and Do is forced to 0.

## Timing
- Read latency is 1 cycle: the address is presented before edge N and data is valid after edge N. There is no combinational path from address to Do.
- Write to read on port A, same address: new data is visible on a read issued in the cycle after the write.
- Scrub duration is exactly WORDS edges after RSTn rises. READY is visible high after the WORDS-th edge, and the first access is accepted on the next edge.
- CLR to READY low: 1 edge. Scrub complete: WORDS further edges.
- READY is a registered output with no glitch on deassert.

## Test plan
- Reset release with WORDS=256: READY stays 0 for 255 edges and is 1 after edge 256; a port B read of every address then returns 0x00000000.
- Byte writes: write 0xDEADBEEF to A_A=0x10 with WE_A=4'hF, then 0x000000AA with WE_A=4'h1. Read A_A=0x10 returns 0xDEADBEAA one cycle later; EN low afterwards holds Do_A.
- Collision: port A writes 0x11223344 with WE_A=4'hC to address 5 holding 0xAAAAAAAA, and port B reads address 5 in the same cycle. Do_A=0xAAAAAAAA; Do_B=0x1122AAAA when BYPASS=1 and 0xAAAAAAAA when BYPASS=0.
- Out-of-range with WORDS=200, AW=8: write 0xFFFFFFFF to address 250, then read addresses 250 and 50. Both return 0, proving no aliasing.
- CLR after filling memory: READY drops on the next edge, port accesses during SCRUB are ignored, READY returns after 256 edges, and all words read 0.
- RSTn pulsed low at scrub count 100: outputs go 0 immediately, and the scrub restarts so that READY rises 256 edges after release.
